// File: rtl/uart_pkg.sv
// Shared UART definitions: auto-baud FSM states and 0x55 sync-measurement constants.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GUARD,
    WAIT_START,
    MEASURE,
    CALC,
    DONE
  } state_t;

  // A 0x55 frame yields five falling edges spanning 8 bit periods = 128 x16 ticks.
  localparam int SYNC_EDGES = 5;
  localparam int ROUND_ADD  = 64;
  localparam int DIV_SHIFT  = 7;

endpackage

// File: rtl/rx_fall_sync.sv
// Two-flop synchronizer for the raw RX pin plus a one-cycle falling-edge strobe.
module rx_fall_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  output logic sample,
  output logic fall
);

  logic meta, sync, prev;

  // The line idles high, so reset to 1 to avoid a false edge on reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      sync <= 1'b1;
      prev <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make each flop sample the previous stage's old value.
      meta <= rx;
      sync <= meta;
      prev <= sync;
    end
  end

  assign sample = sync;
  assign fall   = prev & ~sync;

endmodule

// File: rtl/uart_autobaud.sv
// Auto-baud controller: times the falling edges of a 0x55 sync character and
// derives the x16 oversample divisor, holding the last good value meanwhile.
module uart_autobaud
  import uart_pkg::*;
#(
  parameter int CNT_W       = 20,
  parameter int DIV_W       = 12,
  parameter int DEFAULT_DIV = 175,
  parameter int GUARD_CYC   = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx,
  input  logic             start,
  input  logic             abort,
  output logic [DIV_W-1:0] divisor,
  output logic             div_valid,
  output logic             locked,
  output logic             err,
  output logic             busy
);

  localparam int GW   = $clog2(GUARD_CYC + 1);
  localparam int NIVL = SYNC_EDGES - 1;

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [CNT_W:0]   wide_t;
  typedef logic [DIV_W-1:0] div_t;
  typedef logic [GW-1:0]    guard_t;

  localparam cnt_t CNT_MAX = '1;

  state_t state, state_nx;
  logic   sample, fall;
  guard_t guard_cnt;
  cnt_t   int_cnt;
  logic [2:0] edge_cnt;
  cnt_t   ivl [NIVL];
  cnt_t   total, diff;
  wide_t  quot;
  logic   tol_fail, div_zero, div_big;
  logic   start_ok, fail, success;

  rx_fall_sync u_rx_fall_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .rx     (rx),
    .sample (sample),
    .fall   (fall)
  );

  // ---------------------------------------------------------------------------
  // Measurement arithmetic: rounded divisor and interval consistency check.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    total    = '0;
    diff     = '0;
    tol_fail = 1'b0;
    for (int k = 0; k < NIVL; k++) begin
      total = total + ivl[k];
    end
    for (int k = 1; k < NIVL; k++) begin
      diff = (ivl[k] >= ivl[0]) ? ivl[k] - ivl[0] : ivl[0] - ivl[k];
      if (diff > (ivl[0] >> 2)) tol_fail = 1'b1;
    end
    quot     = ({1'b0, total} + wide_t'(ROUND_ADD)) >> DIV_SHIFT;
    div_zero = (quot == '0);
    div_big  = (quot > wide_t'((2 ** DIV_W) - 1));
  end

  // ---------------------------------------------------------------------------
  // Next-state logic; abort overrides everything, including a same-cycle start.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nx = state;
    start_ok = 1'b0;
    fail     = 1'b0;
    success  = 1'b0;
    if (abort) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state_nx = GUARD;
            start_ok = 1'b1;
          end
        end
        GUARD:      if (guard_cnt == guard_t'(GUARD_CYC)) state_nx = WAIT_START;
        WAIT_START: if (fall) state_nx = MEASURE;
        MEASURE: begin
          if (int_cnt == CNT_MAX) begin
            fail     = 1'b1;
            state_nx = IDLE;
          end else if (fall && edge_cnt == 3'(NIVL)) begin
            state_nx = CALC;
          end
        end
        CALC: begin
          if (tol_fail || div_zero || div_big) begin
            fail     = 1'b1;
            state_nx = IDLE;
          end else begin
            success  = 1'b1;
            state_nx = DONE;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Guard, interval and edge counters.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      guard_cnt <= '0;
      int_cnt   <= '0;
      edge_cnt  <= '0;
    end else begin
      if (start_ok || !sample) begin
        guard_cnt <= '0;
      end else if (state == GUARD && guard_cnt != guard_t'(GUARD_CYC)) begin
        guard_cnt <= guard_cnt + guard_t'(1);
      end

      // Restarting at 1 makes the latched value equal the strobe-to-strobe distance.
      if (fall) begin
        int_cnt <= cnt_t'(1);
      end else if (state == MEASURE && int_cnt != CNT_MAX) begin
        int_cnt <= int_cnt + cnt_t'(1);
      end

      if (state == WAIT_START && fall) begin
        edge_cnt <= 3'd1;
      end else if (state == MEASURE && fall) begin
        edge_cnt <= edge_cnt + 3'd1;
      end
    end
  end

  // NOTE: the interval array needs no reset; all four entries are written before CALC reads them.
  always_ff @(posedge clk) begin
    if (state == MEASURE && fall) begin
      ivl[2'(edge_cnt - 3'd1)] <= int_cnt;
    end
  end

  // ---------------------------------------------------------------------------
  // State and output registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      divisor   <= div_t'(DEFAULT_DIV);
      div_valid <= 1'b0;
      locked    <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nx;
      div_valid <= success;
      err       <= fail;
      if (success) begin
        divisor <= div_t'(quot);
        locked  <= 1'b1;
      end else if (abort || start_ok || fail) begin
        locked  <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE) && (state != DONE);

endmodule

// File: doc/uart_autobaud.md
# uart_autobaud

Auto-baud controller for the UART: measures a received 0x55 sync character on the RX pin, computes the x16-oversample clock divisor, and hands it to the runtime-programmable baud tick generator. It sits between the RX pin and the baud generator's divisor input. It holds the last good divisor, so the receiver and transmitter keep running while a new measurement is armed.

## Interface
- CNT_W, 20: width of the interval and total cycle counters.
- DIV_W, 12: divisor width; matches the baud generator's 12-bit counter.
- DEFAULT_DIV, 175: divisor value after reset (27 MHz / (9600*16)).
- GUARD_CYC, 64: consecutive high cycles required on RX before the start edge is accepted.

- clk  in  1  system clock.
- rst_n  in  1  reset rst_n, asynchronous, active-low; clock clk.
- rx  in  1  raw asynchronous UART RX line.
- start  in  1  one-cycle pulse that arms a measurement.
- abort  in  1  one-cycle pulse that returns to IDLE silently.
- divisor  out  DIV_W  current baud divisor; drives the baud generator.
- div_valid  out  1  one-cycle pulse when divisor is updated.
- locked  out  1  high while divisor comes from a successful measurement.
- err  out  1  one-cycle pulse when a measurement fails.
- busy  out  1  high in every state except IDLE and DONE.

## Operation
- RX passes through a 2-FF synchronizer. A fall strobe asserts for one cycle when the synchronized sample goes 1→0. Rising edges are ignored.
- 0x55 is sent LSB first with a start bit, giving five falling edges at bit times 0, 2, 4, 6 and 8. The span from strobe 1 to strobe 5 is 8 bit periods = 128 x16 ticks.
- Interval I_k is the number of clk cycles between strobe k−1 and strobe k (k = 2..5). An interval counter resets on each strobe and saturates at 2^CNT_W−1.
- TOTAL = I2+I3+I4+I5, held in CNT_W bits.
- The computed divisor is (TOTAL + 64) >> 7, i.e. rounded to nearest.
- Tolerance check: for k = 3..5, the measurement fails if |I_k − I2| > (I2 >> 2).
- FSM:
  - IDLE: start → GUARD.
  - GUARD: counts consecutive high samples. A low sample restarts the count. Count = GUARD_CYC → WAIT_START.
  - WAIT_START: strobe → MEASURE with the edge counter at 1.
  - MEASURE: each strobe latches I_k and increments the edge counter. The 5th strobe → CALC.
  - CALC: one cycle. Success → DONE; any failure → IDLE.
  - DONE: start → GUARD.
- Failure conditions, each giving err = 1 for one cycle and a return to IDLE:
  - tolerance violated;
  - interval counter saturated in MEASURE;
  - computed divisor = 0;
  - computed divisor > 2^DIV_W−1.
- On success, divisor is loaded, div_valid = 1 for one cycle and locked = 1.
- On failure, divisor keeps its previous value.
- locked clears when start is accepted, on abort, and on err.
- abort is honoured from any state: go to IDLE, no err, divisor unchanged. abort wins over start in the same cycle.
- start is ignored while busy = 1.

## Timing
- Reset values: state = IDLE, divisor = DEFAULT_DIV, div_valid = 0, locked = 0, err = 0, busy = 0.
- The fall strobe follows the rx pin transition by 2–3 clk cycles (synchronizer plus edge detect).
- div_valid and the new divisor value appear together, 2 cycles after the 5th strobe (latch cycle, then CALC).
- err asserts in the cycle after CALC, or in the cycle after the interval counter saturates.
- busy rises the cycle after start is accepted and falls in the same cycle that DONE or IDLE is entered.
- Reset asserted mid-measurement returns every output to its reset value immediately (asynchronous).

## Structure
- Shared package uart_pkg:
  - state enum: IDLE, GUARD, WAIT_START, MEASURE, CALC, DONE;
  - constants SYNC_EDGES = 5, ROUND_ADD = 64, DIV_SHIFT = 7.
- Sub-module rx_fall_sync: 2-FF synchronizer plus falling-edge strobe. The same block is reused by the UART receiver.

## Test plan
- Reset, then no stimulus: divisor = 175, locked = 0, busy = 0, err never pulses.
- start, rx idle for 100 cycles, then 0x55 at a 1600-cycle bit period: div_valid pulses once, divisor = 100, locked = 1, busy = 0.
- 0x55 with bit periods alternating 1600/1700 (within tolerance): divisor = 103 (TOTAL 13200, (13200+64)>>7 = 103), locked = 1.
- 0x55 with the third interval stretched to 4400 cycles: err pulses once, divisor stays 100, locked = 0.
- start, then rx held low for 2^20 cycles after the first fall: err pulses once on saturation, state = IDLE.
- abort issued during MEASURE, and abort issued together with start while in DONE:
  - no err;
  - divisor unchanged;
  - state = IDLE;
  - a following start with a 0x55 at a 16-cycle bit period (TOTAL 128) gives divisor = 1.
